fib_bcd_display: RTL and testbench
==================================

Name: fib_bcd_display

Overview:
- Downstream consumer of the 11-bit Fibonacci value produced by the sequence generator.
- Detects a change in the incoming binary value and converts it to 4-digit BCD with an iterative shift/add-3 (double-dabble) engine.
- Drives the board's 4-digit active-low seven-segment display, time-multiplexed, with optional leading-zero blanking.

Parameters:
- N, 11, input binary width; legal 1..13, so the maximum 8191 fits in 4 BCD digits.
- REFRESH_BITS, 17, prescaler width; the digit advances every 2^REFRESH_BITS clocks (~763 Hz at 100 MHz).
- BLANK_LZ, 1, 1 = blank leading zero digits; digit 0 is always lit.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- DATA_IN  input  N  binary value to display (the generator's DATA).
- BUSY  output  1  high while a conversion is in progress (states CONV, UPDT).
- SEGS  output  8  active-low segments {a,b,c,d,e,f,g,dp}; dp always 1 (off).
- DISP_EN  output  4  active-low digit enables; bit0 = ones digit.

Behaviour:
- Reset: state IDLE, LAST=0, DISP_BCD=16'h0000, prescaler=0, digit select=0.
  - Outputs in reset: BUSY=0, DISP_EN=4'b1110, SEGS=8'h03 (shows "0").
- FSM states: IDLE, CONV, UPDT.
  - IDLE: on an edge where DATA_IN != LAST, capture SHIFT<=DATA_IN and CAP<=DATA_IN, clear BCD<=0 and CNT<=0, go to CONV. Otherwise stay in IDLE.
  - CONV: each edge, add 3 to every BCD nibble >=5, then shift {BCD,SHIFT} left one bit, and increment CNT. When CNT==N-1 on that edge, go to UPDT. CONV lasts exactly N cycles.
  - UPDT: DISP_BCD<=BCD, LAST<=CAP, go to IDLE.
- Latency: with change detected at edge k, DISP_BCD updates at edge k+N+1 (k+12 for N=11).
- BUSY is registered state decode; it is high from edge k through edge k+N+1.
- DATA_IN changes while BUSY are ignored. The captured value completes conversion. IDLE then re-compares and starts a new conversion if DATA_IN still differs from LAST. A value that changes and returns to LAST while BUSY triggers nothing.
- Once reset deasserts, a nonzero DATA_IN starts a conversion on the first edge.
- RST asserted mid-conversion aborts immediately to reset values; the partial result is discarded.
- Multiplexer:
  - The prescaler free-runs and wraps from all-ones to 0.
  - On the wrap edge, the 2-bit digit select increments 0->1->2->3->0.
  - DISP_EN is the one-hot-low of the digit select.
  - SEGS decodes DISP_BCD nibble[sel].
- Blanking (BLANK_LZ=1):
  - Digit 3 blanks when it is 0.
  - Digit 2 blanks when digits 3..2 are 0.
  - Digit 1 blanks when digits 3..1 are 0.
  - A blanked digit drives SEGS=8'hFF; DISP_EN is unchanged.
- SEGS and DISP_EN are combinational from registers only; there is no path from DATA_IN to any output.
- Segment patterns for digits 0..9: 03,9F,25,0D,99,49,41,1F,01,09. Nibbles 10..15 cannot occur; decode them to 8'hFF.

Decomposition:
- Shared package/header fib_disp_pkg holds:
  - state encoding (IDLE=2'b00, CONV=2'b01, UPDT=2'b10);
  - the ten segment constants and SEG_BLANK=8'hFF.
- One sub-module, bin2bcd_iter, contains the IDLE/CONV/UPDT engine: change detect, CAP/LAST, SHIFT/BCD/CNT.
  - Its outputs are DISP_BCD[15:0] and BUSY.
  - The top level adds the prescaler, digit select, blanking and segment decode.

Test Plan:
- Bench uses REFRESH_BITS=2.
- Reset, DATA_IN=0 -> BUSY stays 0. Digit 0 shows SEGS=8'h03; digits 1..3 show 8'hFF. DISP_EN cycles 1110,1101,1011,0111 every 4 clocks.
- DATA_IN=987 after reset -> BUSY high 12 cycles, DISP_BCD=16'h0987 at edge k+12. Digits show 1F (ones), 01, 09, thousands FF (blanked).
- DATA_IN=2047 -> DISP_BCD=16'h2047. Digits show 1F, 99, 03 (interior zero lit), 25.
- DATA_IN 5 -> 8 at third CONV cycle -> first result 16'h0005. BUSY drops for one IDLE edge, then a second conversion yields 16'h0008.
- RST pulsed mid-CONV while DATA_IN=610 -> immediate reset outputs (BUSY=0, DISP_BCD=0). After release, the conversion restarts and yields 16'h0610.
- BLANK_LZ=0, DATA_IN=1 -> digits 3..1 show 8'h03, digit 0 shows 8'h9F.

Source files
------------

// File: rtl/fib_disp_pkg.sv
// Shared definitions for the Fibonacci BCD display: converter state
// encoding and the active-low seven-segment patterns {a,b,c,d,e,f,g,dp}.
package fib_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CONV = 2'b01,
        UPDT = 2'b10
    } state_t;

    localparam logic [7:0] SEG_0     = 8'h03;
    localparam logic [7:0] SEG_1     = 8'h9F;
    localparam logic [7:0] SEG_2     = 8'h25;
    localparam logic [7:0] SEG_3     = 8'h0D;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h49;
    localparam logic [7:0] SEG_6     = 8'h41;
    localparam logic [7:0] SEG_7     = 8'h1F;
    localparam logic [7:0] SEG_8     = 8'h01;
    localparam logic [7:0] SEG_9     = 8'h09;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Non-decimal nibbles never come out of the converter; show them dark.
    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Change-triggered iterative binary to 4-digit BCD converter
// (shift/add-3). A new value is captured only from IDLE, so input changes
// during a conversion are ignored until IDLE re-compares against LAST.
//
// Handshake: there is no valid/ready pair here. busy is high while the
// engine is in CONV or UPDT; disp_bcd holds the last completed result and
// changes only on the UPDT edge.
module bin2bcd_iter
    import fib_disp_pkg::*;
#(
    parameter int N = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] data_in,
    output logic [15:0]  disp_bcd,
    output logic         busy,
    output state_t       state_dbg
);

    localparam logic [3:0] CNT_LAST = 4'(N - 1);

    state_t       state;
    logic [N-1:0] last;
    logic [N-1:0] cap;
    logic [N-1:0] shift;
    logic [15:0]  bcd;
    logic [3:0]   cnt;
    logic [15:0]  bcd_adj;

    // Add-3 correction of every nibble that would overflow past 9 on the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Converter FSM: detect change, run N shift steps, publish result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last     <= '0;
            cap      <= '0;
            shift    <= '0;
            bcd      <= '0;
            cnt      <= '0;
            disp_bcd <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_in != last) begin
                        shift <= data_in;
                        cap   <= data_in;
                        bcd   <= '0;
                        cnt   <= '0;
                        state <= CONV;
                        busy  <= 1'b1;
                    end
                end
                CONV: begin
                    bcd   <= {bcd_adj[14:0], shift[N-1]};
                    shift <= shift << 1;
                    cnt   <= cnt + 4'd1;
                    if (cnt == CNT_LAST) begin
                        state <= UPDT;
                    end
                end
                UPDT: begin
                    disp_bcd <= bcd;
                    last     <= cap;
                    state    <= IDLE;
                    busy     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: rtl/fib_bcd_display.sv
// Four-digit multiplexed seven-segment display of an N-bit binary value.
// The converter supplies a stable BCD word; this level scans the digits
// and applies optional leading-zero blanking. Outputs depend on registers
// only, never directly on data_in.
module fib_bcd_display
    import fib_disp_pkg::*;
#(
    parameter int N            = 11,
    parameter int REFRESH_BITS = 17,
    parameter int BLANK_LZ     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] data_in,
    output logic         busy,
    output logic [7:0]   segs,
    output logic [3:0]   disp_en,
    output state_t       state_dbg
);

    logic [15:0]             disp_bcd;
    logic [REFRESH_BITS-1:0] prescaler;
    logic [1:0]              sel;
    logic [3:0]              digit;
    logic                    blank;

    bin2bcd_iter #(
        .N (N)
    ) u_conv (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .disp_bcd  (disp_bcd),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // Free-running prescaler; the digit select steps on each wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            sel       <= 2'd0;
        end else begin
            prescaler <= prescaler + 1'b1;
            if (&prescaler) begin
                sel <= sel + 2'd1;
            end
        end
    end

    // Pick the active digit, decide blanking and drive segments/enables.
    always_comb begin
        digit = disp_bcd[3:0];
        blank = 1'b0;
        case (sel)
            2'd0: digit = disp_bcd[3:0];
            2'd1: digit = disp_bcd[7:4];
            2'd2: digit = disp_bcd[11:8];
            2'd3: digit = disp_bcd[15:12];
            default: digit = disp_bcd[3:0];
        endcase
        if (BLANK_LZ != 0) begin
            case (sel)
                2'd1: blank = (disp_bcd[15:4] == 12'h000);
                2'd2: blank = (disp_bcd[15:8] == 8'h00);
                2'd3: blank = (disp_bcd[15:12] == 4'h0);
                default: blank = 1'b0;
            endcase
        end
        segs    = blank ? SEG_BLANK : seg_decode(digit);
        disp_en = ~(4'b0001 << sel);
    end

endmodule

// File: tb/tb_fib_bcd_display.sv
// Self-checking bench for fib_bcd_display: two instances (blanking on and
// off) share the stimulus; expectations come from decimal arithmetic on
// the driven value and a count of clock edges since reset.
module tb_fib_bcd_display;
    import fib_disp_pkg::*;

    localparam int N  = 11;
    localparam int RB = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] data_in;
    logic         busy, busy_nb;
    logic [7:0]   segs, segs_nb;
    logic [3:0]   disp_en, disp_en_nb;
    logic [1:0]   state_dbg, state_nb;

    fib_bcd_display #(.N(N), .REFRESH_BITS(RB), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .busy(busy),
        .segs(segs), .disp_en(disp_en), .state_dbg(state_dbg)
    );

    fib_bcd_display #(.N(N), .REFRESH_BITS(RB), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst(rst), .data_in(data_in), .busy(busy_nb),
        .segs(segs_nb), .disp_en(disp_en_nb), .state_dbg(state_nb)
    );

    // Clock and reset-relative edge count (the scan position model).
    always #5 clk = ~clk;

    int mdl_edges;
    always @(posedge clk or posedge rst) begin
        if (rst) mdl_edges <= 0;
        else     mdl_edges <= mdl_edges + 1;
    end

    // Scoreboard state.
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  seg_tab[10];
    int          shown;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] exp_seg(input int v, input int i, input bit lz);
        int p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        if (lz && i > 0 && v < p) return 8'hFF;
        return seg_tab[(v / p) % 10];
    endfunction

    // Watch 16 clocks of scanning with a stable value on the display.
    task automatic scan(input string tag);
        int         sel;
        logic [3:0] en_exp;
        repeat (16) begin
            @(negedge clk);
            sel    = (mdl_edges / 4) % 4;
            en_exp = ~(4'b0001 << sel);
            check($sformatf("%s_busy", tag), 32'(busy), 32'd0);
            check($sformatf("%s_en%0d", tag, sel), 32'(disp_en), 32'(en_exp));
            check($sformatf("%s_seg%0d", tag, sel), 32'(segs), 32'(exp_seg(shown, sel, 1'b1)));
            check($sformatf("%s_en_nb%0d", tag, sel), 32'(disp_en_nb), 32'(en_exp));
            check($sformatf("%s_seg_nb%0d", tag, sel), 32'(segs_nb), 32'(exp_seg(shown, sel, 1'b0)));
        end
    endtask

    // Follow one conversion: busy for N+1 samples, result on sample N+1.
    task automatic observe_conv(input string tag, input int v);
        exp_q.push_back(to_bcd(v));
        for (int j = 0; j <= N + 1; j++) begin
            @(negedge clk);
            check($sformatf("%s_busy%0d", tag, j), 32'(busy), 32'(j <= N));
            if (j == N)
                check($sformatf("%s_old", tag), 32'(dut.disp_bcd), 32'(to_bcd(shown)));
            if (j == N + 1)
                check($sformatf("%s_bcd", tag), 32'(dut.disp_bcd), 32'(exp_q.pop_front()));
        end
        shown = v;
    endtask

    task automatic start(input string tag, input int v);
        @(negedge clk);
        data_in = N'(v);
        observe_conv(tag, v);
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s_busy", tag), 32'(busy), 32'd0);
        check($sformatf("%s_bcd", tag), 32'(dut.disp_bcd), 32'h0);
        check($sformatf("%s_en", tag), 32'(disp_en), 32'b1110);
        check($sformatf("%s_seg", tag), 32'(segs), 32'h03);
        check($sformatf("%s_seg_nb", tag), 32'(segs_nb), 32'h03);
        check($sformatf("%s_state", tag), 32'(state_dbg), 32'(IDLE));
    endtask

    initial begin
        int v;
        seg_tab = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
        shown   = 0;
        rst     = 1'b1;
        data_in = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Zero input: nothing converts, display shows "0" with blanking.
        scan("idle0");

        start("c987", 987);
        scan("s987");
        start("c2047", 2047);
        scan("s2047");

        // 5 then 8 arriving during the third CONV edge.
        @(negedge clk);
        data_in = N'(5);
        exp_q.push_back(to_bcd(5));
        exp_q.push_back(to_bcd(8));
        for (int j = 0; j <= 2 * N + 3; j++) begin
            @(negedge clk);
            check($sformatf("b2b_busy%0d", j), 32'(busy),
                  32'((j <= N) || (j >= N + 2 && j <= 2 * N + 2)));
            if (j == 2) data_in = N'(8);
            if (j == N + 1)
                check("b2b_first", 32'(dut.disp_bcd), 32'(exp_q.pop_front()));
            if (j == 2 * N + 3)
                check("b2b_second", 32'(dut.disp_bcd), 32'(exp_q.pop_front()));
        end
        shown = 8;
        scan("s8");

        // Reset in the middle of a conversion, then restart after release.
        @(negedge clk);
        data_in = N'(610);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst   = 1'b0;
        shown = 0;
        observe_conv("restart", 610);
        scan("s610");

        // Random values across the generator's range.
        repeat (6) begin
            v = $urandom_range(0, 2047);
            if (v == shown) v = (v + 1) % 2048;
            start($sformatf("rnd%0d", v), v);
            scan($sformatf("srnd%0d", v));
        end

        // Value 1: blanking instance shows one digit, the other shows 0001.
        start("c1", 1);
        scan("s1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
